// File: rtl/ransac_consensus_accum.sv
// ransac_consensus_accum
//  Consensus-score accumulator for a RANSAC line fitter. For each candidate
//  line (a, b) it consumes one inlier flag per point, counts the inliers,
//  then compares the score against the best model seen so far and keeps the
//  winner (ties keep the earlier model).
//
// Ports
//  clk, reset           clock; asynchronous active-high reset clearing all state
//  start                evaluate a new model (accepted only in IDLE)
//  line_a_in/line_b_in  candidate line coefficients, latched on start
//  num_points           number of point flags for this model, latched on start
//  pt_valid/pt_ready    point-flag handshake; inlier_in is the flag
//  clear_best           drop the stored best model (accepted only in IDLE)
//  busy                 high while counting or comparing
//  done                 one-cycle pulse when count_out/best_* are updated
//  count_out            inlier count of the last completed model
//  best_count/best_a/best_b/best_valid  best model stored so far
module ransac_consensus_accum #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] line_a_in,
  input  logic [DATA_W-1:0] line_b_in,
  input  logic [CNT_W-1:0]  num_points,
  input  logic              pt_valid,
  output logic              pt_ready,
  input  logic              inlier_in,
  input  logic              clear_best,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count_out,
  output logic [CNT_W-1:0]  best_count,
  output logic [DATA_W-1:0] best_a,
  output logic [DATA_W-1:0] best_b,
  output logic              best_valid
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COUNT   = 2'd1;
  localparam logic [1:0] S_COMPARE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  count_out_q, count_out_d;
  logic [CNT_W-1:0]  best_count_q, best_count_d;
  logic [DATA_W-1:0] best_a_q, best_a_d;
  logic [DATA_W-1:0] best_b_q, best_b_d;
  logic              best_valid_q, best_valid_d;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    count_out_d  = count_out_q;
    best_count_d = best_count_q;
    best_a_d     = best_a_q;
    best_b_d     = best_b_q;
    best_valid_d = best_valid_q;

    case (state_q)
      S_IDLE: begin
        // The clear only touches best_*, so a simultaneous start still lands
        // in COMPARE with best_valid low and becomes the new best.
        if (clear_best) begin
          best_valid_d = 1'b0;
          best_count_d = '0;
          best_a_d     = '0;
          best_b_d     = '0;
        end
        if (start) begin
          a_d     = line_a_in;
          b_d     = line_b_in;
          cnt_d   = '0;
          rem_d   = num_points;
          state_d = (num_points != '0) ? S_COUNT : S_COMPARE;
        end
      end
      S_COUNT: begin
        if (pt_valid) begin
          cnt_d = cnt_q + CNT_W'(inlier_in);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_COMPARE;
          end
        end
      end
      S_COMPARE: begin
        count_out_d = cnt_q;
        // Strict compare: an equal score keeps the earlier model.
        if (!best_valid_q || (cnt_q > best_count_q)) begin
          best_valid_d = 1'b1;
          best_count_d = cnt_q;
          best_a_d     = a_q;
          best_b_d     = b_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      rem_q        <= '0;
      count_out_q  <= '0;
      best_count_q <= '0;
      best_a_q     <= '0;
      best_b_q     <= '0;
      best_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      count_out_q  <= count_out_d;
      best_count_q <= best_count_d;
      best_a_q     <= best_a_d;
      best_b_q     <= best_b_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign pt_ready   = (state_q == S_COUNT);
  assign busy       = (state_q == S_COUNT) || (state_q == S_COMPARE);
  assign done       = (state_q == S_DONE);
  assign count_out  = count_out_q;
  assign best_count = best_count_q;
  assign best_a     = best_a_q;
  assign best_b     = best_b_q;
  assign best_valid = best_valid_q;

endmodule

// File: tb/tb_ransac_consensus_accum.sv
// Directed bench for ransac_consensus_accum: inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_ransac_consensus_accum;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] line_a_in = '0;
  logic [DATA_W-1:0] line_b_in = '0;
  logic [CNT_W-1:0]  num_points = '0;
  logic              pt_valid = 1'b0;
  logic              pt_ready;
  logic              inlier_in = 1'b0;
  logic              clear_best = 1'b0;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count_out;
  logic [CNT_W-1:0]  best_count;
  logic [DATA_W-1:0] best_a;
  logic [DATA_W-1:0] best_b;
  logic              best_valid;

  int errors = 0;
  int checks = 0;

  ransac_consensus_accum #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .line_a_in(line_a_in), .line_b_in(line_b_in), .num_points(num_points),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .inlier_in(inlier_in),
    .clear_best(clear_best), .busy(busy), .done(done),
    .count_out(count_out), .best_count(best_count),
    .best_a(best_a), .best_b(best_b), .best_valid(best_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue start from IDLE, then feed n flags with 'gap' idle cycles before
  // each point. Returns right after the last accepting edge (COMPARE state).
  task automatic run_model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input int n, input logic [15:0] flags, input int gap);
    start = 1'b1; line_a_in = a; line_b_in = b; num_points = CNT_W'(n);
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        pt_valid = 1'b0;
        tick();
      end
      pt_valid = 1'b1; inlier_in = flags[i];
      tick();
    end
    pt_valid = 1'b0; inlier_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0d expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", busy); end
    checks++; if (pt_ready !== 1'b0) begin errors++; $display("FAIL reset_pt_ready: got %0d expected 0", pt_ready); end
    checks++; if (best_valid !== 1'b0) begin errors++; $display("FAIL reset_best_valid: got %0d expected 0", best_valid); end
    checks++; if (count_out !== '0) begin errors++; $display("FAIL reset_count_out: got %0d expected 0", count_out); end
  endtask

  task automatic test_basic();
    run_model(32'd3, 32'd5, 4, 16'b1101, 0);
    checks++; if (busy !== 1'b1 || done !== 1'b0 || pt_ready !== 1'b0) begin errors++;
      $display("FAIL basic_compare_state: got busy=%0d done=%0d rdy=%0d expected 1 0 0", busy, done, pt_ready); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %0d expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %0d expected 0", busy); end
    checks++; if (count_out !== 16'd3) begin errors++; $display("FAIL basic_count_out: got %0d expected 3", count_out); end
    checks++; if (best_count !== 16'd3 || best_a !== 32'd3 || best_b !== 32'd5 || best_valid !== 1'b1) begin errors++;
      $display("FAIL basic_best: got cnt=%0d a=%0d b=%0d v=%0d expected 3 3 5 1", best_count, best_a, best_b, best_valid); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %0d expected 0", done); end
  endtask

  task automatic test_compare();
    // lower score: best unchanged
    run_model(32'd7, 32'd2, 4, 16'b0011, 0);
    tick();
    checks++; if (count_out !== 16'd2) begin errors++; $display("FAIL lower_count_out: got %0d expected 2", count_out); end
    checks++; if (best_count !== 16'd3 || best_a !== 32'd3 || best_b !== 32'd5) begin errors++;
      $display("FAIL lower_best: got cnt=%0d a=%0d b=%0d expected 3 3 5", best_count, best_a, best_b); end
    tick();
    // equal score: earlier model kept
    run_model(32'd8, 32'd8, 4, 16'b0111, 0);
    tick();
    checks++; if (count_out !== 16'd3 || best_a !== 32'd3 || best_b !== 32'd5) begin errors++;
      $display("FAIL tie_keeps_first: got cnt=%0d a=%0d b=%0d expected 3 3 5", count_out, best_a, best_b); end
    tick();
    // higher score replaces best
    run_model(32'd7, 32'd2, 4, 16'b1111, 0);
    tick();
    checks++; if (best_count !== 16'd4 || best_a !== 32'd7 || best_b !== 32'd2) begin errors++;
      $display("FAIL higher_best: got cnt=%0d a=%0d b=%0d expected 4 7 2", best_count, best_a, best_b); end
    tick();
  endtask

  task automatic test_gapped();
    start = 1'b1; line_a_in = 32'd11; line_b_in = 32'd12; num_points = 16'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pt_valid = 1'b0;
      tick();
      tick();
      checks++; if (pt_ready !== 1'b1 || busy !== 1'b1) begin errors++;
        $display("FAIL gap_stall_ready: got rdy=%0d busy=%0d expected 1 1", pt_ready, busy); end
      pt_valid = 1'b1; inlier_in = 1'b1;
      tick();
    end
    pt_valid = 1'b0; inlier_in = 1'b0;
    checks++; if (done !== 1'b0 || pt_ready !== 1'b0) begin errors++;
      $display("FAIL gap_compare: got done=%0d rdy=%0d expected 0 0", done, pt_ready); end
    tick();
    checks++; if (done !== 1'b1 || count_out !== 16'd3) begin errors++;
      $display("FAIL gap_done: got done=%0d cnt=%0d expected 1 3", done, count_out); end
    checks++; if (best_count !== 16'd4 || best_a !== 32'd7) begin errors++;
      $display("FAIL gap_best_kept: got cnt=%0d a=%0d expected 4 7", best_count, best_a); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL gap_pulse_width: got %0d expected 0", done); end
  endtask

  task automatic test_zero_points();
    do_reset();
    start = 1'b1; line_a_in = 32'd40; line_b_in = 32'd41; num_points = 16'd0;
    tick();
    start = 1'b0;
    checks++; if (pt_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin errors++;
      $display("FAIL zero_compare: got rdy=%0d busy=%0d done=%0d expected 0 1 0", pt_ready, busy, done); end
    tick();
    checks++; if (done !== 1'b1 || count_out !== 16'd0) begin errors++;
      $display("FAIL zero_done: got done=%0d cnt=%0d expected 1 0", done, count_out); end
    checks++; if (best_valid !== 1'b1 || best_count !== 16'd0 || best_a !== 32'd40 || best_b !== 32'd41) begin errors++;
      $display("FAIL zero_best: got v=%0d cnt=%0d a=%0d b=%0d expected 1 0 40 41", best_valid, best_count, best_a, best_b); end
    tick();
  endtask

  task automatic test_reset_mid();
    run_model(32'd50, 32'd51, 1, 16'b1, 0);
    tick();
    tick();
    start = 1'b1; line_a_in = 32'd60; line_b_in = 32'd61; num_points = 16'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pt_valid = 1'b1; inlier_in = 1'b1;
      tick();
    end
    pt_valid = 1'b0; inlier_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (pt_ready !== 1'b0 || busy !== 1'b0 || best_valid !== 1'b0 || best_count !== '0 ||
                  best_a !== '0 || best_b !== '0 || count_out !== '0 || done !== 1'b0) begin errors++;
      $display("FAIL async_reset_clear: got rdy=%0d busy=%0d v=%0d bc=%0d a=%0d b=%0d co=%0d done=%0d expected all 0",
               pt_ready, busy, best_valid, best_count, best_a, best_b, count_out, done); end
    tick();
    reset = 1'b0;
    tick();
    run_model(32'd70, 32'd71, 2, 16'b11, 0);
    tick();
    checks++; if (done !== 1'b1 || count_out !== 16'd2 || best_count !== 16'd2 || best_a !== 32'd70) begin errors++;
      $display("FAIL after_reset_model: got done=%0d co=%0d bc=%0d a=%0d expected 1 2 2 70", done, count_out, best_count, best_a); end
    tick();
  endtask

  task automatic test_clear_and_start();
    run_model(32'd90, 32'd91, 9, 16'h01FF, 0);
    tick();
    checks++; if (best_count !== 16'd9) begin errors++; $display("FAIL nine_best: got %0d expected 9", best_count); end
    tick();
    clear_best = 1'b1; start = 1'b1; line_a_in = 32'd21; line_b_in = 32'd22; num_points = 16'd3;
    tick();
    clear_best = 1'b0; start = 1'b0;
    // pulses during COUNT must be ignored
    start = 1'b1; clear_best = 1'b1; line_a_in = 32'd99; line_b_in = 32'd98; num_points = 16'd1;
    tick();
    start = 1'b0; clear_best = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pt_valid = 1'b1; inlier_in = (i == 0);
      tick();
    end
    pt_valid = 1'b0; inlier_in = 1'b0;
    tick();
    checks++; if (done !== 1'b1 || count_out !== 16'd1) begin errors++;
      $display("FAIL clear_start_done: got done=%0d co=%0d expected 1 1", done, count_out); end
    checks++; if (best_count !== 16'd1 || best_a !== 32'd21 || best_b !== 32'd22 || best_valid !== 1'b1) begin errors++;
      $display("FAIL clear_start_best: got cnt=%0d a=%0d b=%0d v=%0d expected 1 21 22 1", best_count, best_a, best_b, best_valid); end
    // start during DONE is ignored
    start = 1'b1; num_points = 16'd2;
    tick();
    start = 1'b0;
    checks++; if (pt_ready !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL start_in_done_ignored: got rdy=%0d busy=%0d expected 0 0", pt_ready, busy); end
    // clear_best alone in IDLE
    clear_best = 1'b1;
    tick();
    clear_best = 1'b0;
    checks++; if (best_valid !== 1'b0 || best_count !== '0 || best_a !== '0) begin errors++;
      $display("FAIL clear_only: got v=%0d cnt=%0d a=%0d expected 0 0 0", best_valid, best_count, best_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_compare();
    test_gapped();
    test_zero_points();
    test_reset_mid();
    test_clear_and_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
